systolic_mm_engine: RTL and testbench

// - Parametrised successor of the fixed 4x4 array-with-memory-and-controller: NxN output-stationary systolic
//   MAC array, A/B operand register files, runtime inner dimension k_len, result readout port.
// - Host loads A (N x k_len) and B (k_len x N), pulses ap_start; engine streams skewed operands,

---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_pe.sv | 57 +++++
 rtl/systolic_mm_engine.sv | 158 +++++++++++++++
 tb/tb_systolic_mm_engine.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared state encoding and sizing helpers for the systolic matrix-multiply engine.
// Pure definitions: no logic, no latency, no flow control.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Cycles spent in FEED: last operand reaches PE(N-1,N-1) at cnt = k + 2n - 3.
  function automatic int feed_len(input int k, input int n);
    return k + 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: a/b forwarded one register per hop, acc += a*b while en.
// Latency: one cycle per hop; no backpressure. SYSTOLIC_SAT_EN clips the accumulator and pulses sat.
module systolic_pe #(
  parameter int DW    = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [DW-1:0]    a_in,
  input  logic signed [DW-1:0]    b_in,
  output logic signed [DW-1:0]    a_out,
  output logic signed [DW-1:0]    b_out,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc_nxt;

  assign prod   = (2*DW)'(a_in) * (2*DW)'(b_in);
  assign prod_x = ACC_W'(prod);

`ifdef SYSTOLIC_SAT_EN
  logic [ACC_W:0] sum;

  assign sum = {acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x};

  // Top two sum bits disagree only on overflow; the carry-out bit gives the direction.
  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    sat     = 1'b0;
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat     = en;
      acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_nxt = acc + prod_x;
  assign sat     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (en) acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic matrix multiplier with A/B operand files and result readout.
// Latency: done k_len+2N-1 cycles after ap_start is sampled; no backpressure, host polls busy/done.
// SYSTOLIC_SAT_EN selects saturating accumulation with a sticky sat_flag.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int K_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ap_start,
  input  logic                         stop,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  input  logic                         wr_en_a,
  input  logic [$clog2(N*K_MAX)-1:0]   wr_addr_a,
  input  logic [DW-1:0]                wr_data_a,
  input  logic                         wr_en_b,
  input  logic [$clog2(N*K_MAX)-1:0]   wr_addr_b,
  input  logic [DW-1:0]                wr_data_b,
  input  logic [$clog2(N*N)-1:0]       res_addr,
  output logic [ACC_W-1:0]             res_data,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int AW = $clog2(N * K_MAX);
  localparam int CW = addr_w(K_MAX + 2 * N - 2);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [KW-1:0]           k_lat;
  logic                    sat_r;
  logic                    pe_clear;
  logic                    pe_en;
  logic signed [DW-1:0]    mem_a [N*K_MAX];
  logic signed [DW-1:0]    mem_b [N*K_MAX];
  logic signed [DW-1:0]    a_feed [N];
  logic signed [DW-1:0]    b_feed [N];
  logic signed [DW-1:0]    a_out [N][N];
  logic signed [DW-1:0]    b_out [N][N];
  logic signed [ACC_W-1:0] acc [N*N];
  logic [N*N-1:0]          sat_vec;

  assign pe_clear = (state == CLEAR);
  assign pe_en    = (state == FEED);

  always_ff @(posedge clk) begin
    if (wr_en_a && state == IDLE) mem_a[wr_addr_a] <= wr_data_a;
    if (wr_en_b && state == IDLE) mem_b[wr_addr_b] <= wr_data_b;
  end

  // Row r and column r share the skew: both see operand index cnt - r.
  always_comb begin
    int ka;
    ka = 0;
    for (int r = 0; r < N; r++) begin
      a_feed[r] = '0;
      b_feed[r] = '0;
      ka = int'(cnt) - r;
      if (state == FEED && ka >= 0 && ka < int'(k_lat)) begin
        a_feed[r] = mem_a[AW'(r * K_MAX + ka)];
        b_feed[r] = mem_b[AW'(ka * N + r)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k_lat <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (ap_start) begin
          state <= CLEAR;
          busy  <= 1'b1;
          k_lat <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        end
        CLEAR: begin
          cnt <= '0;
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (k_lat == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= FEED;
          end
        end
        FEED: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (int'(cnt) == feed_len(int'(k_lat), N) - 1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pe_clear) sat_r <= 1'b0;
    else if (|sat_vec)   sat_r <= 1'b1;
  end

  assign sat_flag = sat_r;
  assign res_data = acc[res_addr];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DW-1:0] a_in;
      logic signed [DW-1:0] b_in;

      if (j == 0) begin : g_a_edge
        assign a_in = a_feed[i];
      end else begin : g_a_hop
        assign a_in = a_out[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = b_feed[j];
      end else begin : g_b_hop
        assign b_in = b_out[i-1][j];
      end

      systolic_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (pe_clear),
        .en    (pe_en),
        .a_in  (a_in),
        .b_in  (b_in),
        .a_out (a_out[i][j]),
        .b_out (b_out[i][j]),
        .acc   (acc[i*N+j]),
        .sat   (sat_vec[i*N+j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: vector table, random matrices vs. a plain
// matrix-product model, and hand sequences for stop, busy-time writes and mid-run reset.
module tb_systolic_mm_engine;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int ACC_W = 32;
  localparam int K_MAX = 8;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int AW    = $clog2(N * K_MAX);
  localparam int RW    = $clog2(N * N);
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic             clk = 1'b0;
  logic             rst;
  logic             ap_start;
  logic             stop;
  logic [KW-1:0]    k_len;
  logic             wr_en_a;
  logic [AW-1:0]    wr_addr_a;
  logic [DW-1:0]    wr_data_a;
  logic             wr_en_b;
  logic [AW-1:0]    wr_addr_b;
  logic [DW-1:0]    wr_data_b;
  logic [RW-1:0]    res_addr;
  logic [ACC_W-1:0] res_data;
  logic             busy;
  logic             done;
  logic             sat_flag;

  systolic_mm_engine #(.N(N), .DW(DW), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .ap_start  (ap_start),
    .stop      (stop),
    .k_len     (k_len),
    .wr_en_a   (wr_en_a),
    .wr_addr_a (wr_addr_a),
    .wr_data_a (wr_data_a),
    .wr_en_b   (wr_en_b),
    .wr_addr_b (wr_addr_b),
    .wr_data_b (wr_data_b),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int ma [N][K_MAX];
  int mb [K_MAX][N];

  typedef struct {
    int     pat;
    int     k;
    int     exp_lat;
    longint exp_c00;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // C[i][j] accumulated in k order, as the array does, clipping or wrapping each step.
  function automatic longint model_c(input int i, input int j, input int k, output bit sat);
    longint s;
    s   = 0;
    sat = 1'b0;
    for (int kk = 0; kk < k; kk++) begin
      s += longint'(ma[i][kk]) * longint'(mb[kk][j]);
`ifdef SYSTOLIC_SAT_EN
      if (s > MAXV) begin s = MAXV; sat = 1'b1; end
      else if (s < MINV) begin s = MINV; sat = 1'b1; end
`else
      s = longint'(int'(s));
`endif
    end
    return s;
  endfunction

  task automatic load(input int pat);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++)
        case (pat)
          0:       ma[i][k] = (i == k) ? 1 : 0;
          1:       ma[i][k] = N * i + k + 1;
          2:       ma[i][k] = 3;
          3:       ma[i][k] = -32768;
          default: ma[i][k] = int'($urandom_range(65535)) - 32768;
        endcase
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < N; j++)
        case (pat)
          0:       mb[k][j] = N * k + j + 1;
          1:       mb[k][j] = N * k + j + 17;
          2:       mb[k][j] = -2;
          3:       mb[k][j] = -32768;
          default: mb[k][j] = int'($urandom_range(65535)) - 32768;
        endcase
    for (int idx = 0; idx < N * K_MAX; idx++) begin
      @(negedge clk);
      wr_en_a   = 1'b1;
      wr_addr_a = AW'(idx);
      wr_data_a = DW'(ma[idx / K_MAX][idx % K_MAX]);
      wr_en_b   = 1'b1;
      wr_addr_b = AW'(idx);
      wr_data_b = DW'(mb[idx / N][idx % N]);
    end
    @(negedge clk);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic start(input int k, output int c0);
    @(negedge clk);
    k_len    = KW'(k);
    ap_start = 1'b1;
    c0       = cyc;
    @(negedge clk);
    ap_start = 1'b0;
  endtask

  // lat = edges from the edge before ap_start is sampled to done; -1 if done never came.
  task automatic run(input int k, output int lat, output int bcnt);
    int c0;
    start(k, c0);
    lat  = -1;
    bcnt = 0;
    for (int t = 0; t < 100 && lat < 0; t++) begin
      if (busy) bcnt++;
      if (done) lat = cyc - c0;
      if (lat < 0) @(negedge clk);
    end
  endtask

  task automatic count_done(input int n, output int nd);
    nd = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  task automatic check_results(input string name, input int k);
    int  ke;
    bit  s;
    bit  s_any;
    longint e;
    ke    = (k > K_MAX) ? K_MAX : k;
    s_any = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        @(negedge clk);
        res_addr = RW'(i * N + j);
        #1;
        e = model_c(i, j, ke, s);
        s_any |= s;
        check(name, longint'($signed(res_data)), e);
      end
    check("sat_flag", longint'(sat_flag), longint'(s_any));
  endtask

  task automatic read_c00(output longint v);
    @(negedge clk);
    res_addr = '0;
    #1;
    v = longint'($signed(res_data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int     lat;
    int     bc;
    int     c0;
    int     nd;
    int     ke;
    longint v;

    tbl[0] = '{pat: 0, k: 4,  exp_lat: 12, exp_c00: 1};
    tbl[1] = '{pat: 1, k: 4,  exp_lat: 12, exp_c00: 250};
    tbl[2] = '{pat: 2, k: 1,  exp_lat: 9,  exp_c00: -6};
    tbl[3] = '{pat: 2, k: 0,  exp_lat: 2,  exp_c00: 0};
`ifdef SYSTOLIC_SAT_EN
    tbl[4] = '{pat: 3, k: 4,  exp_lat: 12, exp_c00: 2147483647};
`else
    tbl[4] = '{pat: 3, k: 4,  exp_lat: 12, exp_c00: 0};
`endif
    tbl[5] = '{pat: 1, k: 12, exp_lat: 16, exp_c00: 1284};

    rst = 1'b1; ap_start = 1'b0; stop = 1'b0; k_len = '0;
    wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    res_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
    for (int a = 0; a < N * N; a++) begin
      @(negedge clk);
      res_addr = RW'(a);
      #1;
      check("rst_acc", longint'($signed(res_data)), 0);
    end

    for (int v_i = 0; v_i < 6; v_i++) begin
      load(tbl[v_i].pat);
      run(tbl[v_i].k, lat, bc);
      ke = (tbl[v_i].k > K_MAX) ? K_MAX : tbl[v_i].k;
      check("latency", lat, tbl[v_i].exp_lat);
      check("busy_cycles", bc, (ke == 0) ? 1 : ke + 2 * N - 1);
      @(negedge clk);
      check("done_pulse", done, 0);
      read_c00(v);
      check("c00", v, tbl[v_i].exp_c00);
      check_results("c_tbl", tbl[v_i].k);
    end

    for (int r = 0; r < 6; r++) begin
      ke = int'($urandom_range(K_MAX));
      load(4);
      run(ke, lat, bc);
      check("rnd_latency", lat, (ke == 0) ? 2 : ke + 2 * N);
      check_results("c_rnd", ke);
    end

    // stop in the third FEED cycle: PE(0,0) keeps k=0..2 of the pattern-1 product
    load(1);
    start(4, c0);
    while (cyc < c0 + 4) @(negedge clk);
    check("busy_before_stop", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    read_c00(v);
    check("stop_partial", v, 134);
    count_done(20, nd);
    check("stop_no_done", nd, 0);
    run(4, lat, bc);
    check("restart_latency", lat, 12);
    check_results("c_restart", 4);

    // writes and a second start during busy must be dropped
    start(4, c0);
    wr_en_a   = 1'b1; wr_addr_a = '0; wr_data_a = DW'(999);
    wr_en_b   = 1'b1; wr_addr_b = '0; wr_data_b = DW'(-777);
    ap_start  = 1'b1;
    @(negedge clk);
    wr_en_a = 1'b0; wr_en_b = 1'b0; ap_start = 1'b0;
    count_done(40, nd);
    check("single_done", nd, 1);
    check_results("c_busy_wr", 4);
    run(4, lat, bc);
    check("busy_wr_latency", lat, 12);
    read_c00(v);
    check("busy_wr_c00", v, 250);

    // reset mid-FEED clears accumulators, operand memories survive
    start(4, c0);
    while (cyc < c0 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    for (int a = 0; a < N * N; a++) begin
      @(negedge clk);
      res_addr = RW'(a);
      #1;
      check("rst_mid_acc", longint'($signed(res_data)), 0);
    end
    count_done(20, nd);
    check("rst_mid_no_done", nd, 0);
    run(4, lat, bc);
    check("post_rst_latency", lat, 12);
    read_c00(v);
    check("post_rst_c00", v, 250);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
